// File: rtl/readout_pkg.sv
// readout_pkg: shared widths, header marker default and unpacker FSM states.
package readout_pkg;
    localparam int WORD_W = 12;
    localparam int ENTRY_W = 36;
    localparam int HDR_W = 24;
    localparam logic [WORD_W-1:0] HDR_MARKER_DEF = 12'hEC5;
    localparam int HDR_CNT_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
endpackage

// File: rtl/unpack_word_sel.sv
// unpack_word_sel: picks the next word to emit at or after the current index.
// With DATA_SKIP_NULL_EN defined, zero words of data entries are passed over.
module unpack_word_sel
    import readout_pkg::*;
(
    input  logic [ENTRY_W-1:0] i_entry,
    input  logic               i_is_hdr,
    input  logic [1:0]         i_idx,
    output logic [WORD_W-1:0]  o_word,
    output logic [1:0]         o_sel,
    output logic               o_has,
    output logic               o_last
);
    logic [WORD_W-1:0] w_word0;
    logic [2:0]        w_keep;
    always_comb begin
        w_word0 = i_is_hdr ? i_entry[35:24] : i_entry[11:0];
        w_keep[0] = i_idx == 2'd0;
        w_keep[1] = i_idx <= 2'd1;
        w_keep[2] = i_idx <= 2'd2 && !i_is_hdr;
`ifdef DATA_SKIP_NULL_EN
        w_keep[0] = w_keep[0] && (i_is_hdr || w_word0 != '0);
        w_keep[1] = w_keep[1] && (i_is_hdr || i_entry[23:12] != '0);
        w_keep[2] = w_keep[2] && i_entry[35:24] != '0;
`endif
        o_sel = w_keep[0] ? 2'd0 : w_keep[1] ? 2'd1 : 2'd2;
        o_has = |w_keep;
        o_last = w_keep[0] ? !(w_keep[1] || w_keep[2]) : w_keep[1] ? !w_keep[2] : 1'b1;
        o_word = o_sel == 2'd0 ? w_word0 : o_sel == 2'd1 ? i_entry[23:12] : i_entry[35:24];
    end
endmodule

// File: rtl/data_unpacker.sv
// data_unpacker: pops 36-bit readout FIFO entries and streams them as 12-bit words.
// Optional DATA_SKIP_NULL_EN (in unpack_word_sel) drops zero words of data entries.
module data_unpacker
    import readout_pkg::*;
#(
    parameter logic [WORD_W-1:0] HDR_MARKER = HDR_MARKER_DEF,
    parameter int                HDR_CNT_W  = HDR_CNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rinc,
    input  logic [ENTRY_W-1:0]   i_fifo_out,
    output logic [WORD_W-1:0]    o_dout,
    output logic                 o_dout_is_hdr,
    output logic                 o_dout_valid,
    input  logic                 i_dout_ready,
    output logic                 o_busy,
    output logic [HDR_CNT_W-1:0] o_hdr_count
);
    state_t                r_state, w_next;
    logic [ENTRY_W-1:0]    r_entry;
    logic                  r_is_hdr;
    logic [1:0]            r_idx;
    logic [HDR_CNT_W-1:0]  r_hdr_count;
    logic [WORD_W-1:0]     w_word;
    logic [1:0]            w_sel;
    logic                  w_has, w_last, w_accept, w_done, w_load_hdr;
    unpack_word_sel u_sel (
        .i_entry  (r_entry),
        .i_is_hdr (r_is_hdr),
        .i_idx    (r_idx),
        .o_word   (w_word),
        .o_sel    (w_sel),
        .o_has    (w_has),
        .o_last   (w_last)
    );
    // An emptied entry (no word left, or last word accepted) chains straight into the next fetch.
    always_comb begin
        w_accept = r_state == EMIT && w_has && i_dout_ready;
        w_done = r_state == EMIT && (!w_has || (w_accept && w_last));
        w_load_hdr = i_fifo_out[WORD_W-1:0] == HDR_MARKER;
        o_fifo_rinc = (r_state == IDLE || w_done) && !i_fifo_empty && !i_reset;
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_fifo_empty ? IDLE : LOAD;
            LOAD:    w_next = EMIT;
            EMIT:    w_next = !w_done ? EMIT : i_fifo_empty ? IDLE : LOAD;
            default: w_next = IDLE;
        endcase
        o_dout_valid = r_state == EMIT && w_has;
        o_dout = o_dout_valid ? w_word : '0;
        o_dout_is_hdr = o_dout_valid && r_is_hdr;
        o_busy = r_state != IDLE;
        o_hdr_count = r_hdr_count;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_entry <= '0;
            r_is_hdr <= 1'b0;
            r_idx <= 2'd0;
            r_hdr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD) begin
                r_entry <= i_fifo_out;
                r_is_hdr <= w_load_hdr;
                r_idx <= 2'd0;
                if (w_load_hdr) r_hdr_count <= r_hdr_count + 1'b1;
            end else if (w_accept) begin
                r_idx <= w_sel + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_data_unpacker.sv
// tb_data_unpacker: directed and random entries against a word-list model of the unpacker.
module tb_data_unpacker;
    typedef struct packed {logic last; logic hdr; logic [11:0] w;} exp_t;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_fifo_empty = 1'b1;
    logic        o_fifo_rinc;
    logic [35:0] i_fifo_out = '0;
    logic [11:0] o_dout;
    logic        o_dout_is_hdr, o_dout_valid;
    logic        i_dout_ready = 1'b1;
    logic        o_busy;
    logic [15:0] o_hdr_count;
    logic [35:0] fifo_q[$];
    exp_t        exp_q[$];
    int          total = 0, bad = 0, cyc = 0, rinc_cyc = -100;
    logic [15:0] hdr_exp = '0;
    logic        pend_pop = 1'b0, rnd_ready = 1'b0;
    logic        last_v = 1'b0, last_r = 1'b0, last_h = 1'b0;
    logic [11:0] last_d = '0;
    data_unpacker dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_fifo_empty  (i_fifo_empty),
        .o_fifo_rinc   (o_fifo_rinc),
        .i_fifo_out    (i_fifo_out),
        .o_dout        (o_dout),
        .o_dout_is_hdr (o_dout_is_hdr),
        .o_dout_valid  (o_dout_valid),
        .i_dout_ready  (i_dout_ready),
        .o_busy        (o_busy),
        .o_hdr_count   (o_hdr_count)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask
    task automatic push(input logic [35:0] e);
        logic [11:0] w[$];
        exp_t x;
        logic h;
        h = e[11:0] == 12'hEC5;
        fifo_q.push_back(e);
        i_fifo_empty = 1'b0;
        if (h) begin
            w.push_back(e[35:24]);
            w.push_back(e[23:12]);
            hdr_exp++;
        end else begin
            for (int k = 0; k < 3; k++) begin
`ifdef DATA_SKIP_NULL_EN
                if (e[12*k +: 12] != 12'h000)
`endif
                w.push_back(e[12*k +: 12]);
            end
        end
        foreach (w[k]) begin
            x.last = k == w.size() - 1;
            x.hdr = h;
            x.w = w[k];
            exp_q.push_back(x);
        end
    endtask
    task automatic tick();
        exp_t e;
        #1;
        if (o_fifo_rinc) begin
            chk("rinc_while_empty", i_fifo_empty, 0);
            rinc_cyc = cyc;
        end
        if (o_dout_valid && !last_v) chk("rinc_to_valid", cyc - rinc_cyc, 2);
        if (last_v && !last_r) chk("hold", {o_dout_valid, o_dout_is_hdr, o_dout}, {1'b1, last_h, last_d});
        if (o_dout_valid && i_dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", o_dout_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("word", {o_dout_is_hdr, o_dout}, {e.hdr, e.w});
                chk("rinc_at_last", o_fifo_rinc, e.last && !i_fifo_empty);
            end
        end
        pend_pop = o_fifo_rinc;
        {last_v, last_r, last_h, last_d} = {o_dout_valid, i_dout_ready, o_dout_is_hdr, o_dout};
        @(negedge clk);
        cyc++;
        if (pend_pop && fifo_q.size() != 0) i_fifo_out = fifo_q.pop_front();
        i_fifo_empty = fifo_q.size() == 0;
        if (rnd_ready) i_dout_ready = $urandom_range(0, 3) != 0;
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || o_busy) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_done", n < 400, 1);
    endtask
    task automatic wait_exp(input int sz);
        int n;
        n = 0;
        while (exp_q.size() != sz && n < 40) begin
            tick();
            n++;
        end
        chk("reach_word2", exp_q.size(), sz);
    endtask
    initial begin
        logic [35:0] e;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out", {o_fifo_rinc, o_dout, o_dout_is_hdr, o_dout_valid, o_busy, o_hdr_count}, 0);
        i_reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("empty_idle", {o_fifo_rinc, o_dout_valid, o_busy}, 0);
        end
        push({24'hABCDEF, 12'hEC5});
        drain();
        chk("hdr_count_1", o_hdr_count, 1);
        push({12'h333, 12'h222, 12'h111});
        drain();
        push({12'h789, 12'h456, 12'h123});
        push({24'h0FEDCB, 12'hEC5});
        drain();
        chk("hdr_count_2", o_hdr_count, hdr_exp);
        push({12'hCCC, 12'hBBB, 12'hAAA});
        wait_exp(2);
        i_dout_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("stall_word", {o_dout_valid, o_dout}, {1'b1, 12'hBBB});
        end
        i_dout_ready = 1'b1;
        drain();
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            e[35:32] = 4'($urandom);
            e[31:0] = $urandom;
            if ($urandom_range(0, 3) == 0) e[11:0] = 12'hEC5;
            push(e);
            repeat ($urandom_range(0, 4)) tick();
        end
        drain();
        rnd_ready = 1'b0;
        i_dout_ready = 1'b1;
        chk("hdr_count_rand", o_hdr_count, hdr_exp);
        push({12'h666, 12'h555, 12'h444});
        wait_exp(2);
        i_dout_ready = 1'b0;
        tick();
        i_reset = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_reset", {o_fifo_rinc, o_dout, o_dout_is_hdr, o_dout_valid, o_busy, o_hdr_count}, 0);
        i_reset = 1'b0;
        i_dout_ready = 1'b1;
        exp_q.delete();
        hdr_exp = '0;
        last_v = 1'b0;
        pend_pop = 1'b0;
        push({12'h000, 12'h5A5, 12'h000});
        drain();
        push({12'h000, 12'h000, 12'h000});
        push({12'h321, 12'h000, 12'h654});
        drain();
        chk("hdr_count_end", o_hdr_count, hdr_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
